// File: rtl/int_div_pkg.sv
// Shared types, widths and message helpers for the iterative unsigned divider.
package int_div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultNbits = 32;
  localparam int unsigned ReqW         = 2 * DefaultNbits;
  localparam int unsigned RespW        = 2 * DefaultNbits;

  function automatic logic [ReqW-1:0] pack_req(input logic [DefaultNbits-1:0] dividend,
                                               input logic [DefaultNbits-1:0] divisor);
    return {dividend, divisor};
  endfunction

  function automatic logic [RespW-1:0] pack_resp(input logic [DefaultNbits-1:0] remainder,
                                                 input logic [DefaultNbits-1:0] quotient);
    return {remainder, quotient};
  endfunction

  function automatic logic [DefaultNbits-1:0] req_dividend(input logic [ReqW-1:0] msg);
    return msg[ReqW-1:DefaultNbits];
  endfunction

  function automatic logic [DefaultNbits-1:0] req_divisor(input logic [ReqW-1:0] msg);
    return msg[DefaultNbits-1:0];
  endfunction

  function automatic logic [DefaultNbits-1:0] resp_remainder(input logic [RespW-1:0] msg);
    return msg[RespW-1:DefaultNbits];
  endfunction

  function automatic logic [DefaultNbits-1:0] resp_quotient(input logic [RespW-1:0] msg);
    return msg[DefaultNbits-1:0];
  endfunction

endpackage

// File: rtl/int_div_iterative_dpath.sv
// Restoring-division datapath: remainder/quotient register R, divisor register D,
// N+1-bit compare and the shift/merge step.
module int_div_iterative_dpath
  import int_div_pkg::*;
#(
  parameter int unsigned p_nbits = DefaultNbits
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 use_diff,
  input  logic [p_nbits-1:0]   dividend,
  input  logic [p_nbits-1:0]   divisor,
  output logic                 sub_ok,
  output logic [2*p_nbits-1:0] rem_quo
);

  logic [2*p_nbits-1:0] r_q;
  logic [p_nbits-1:0]   d_q;
  logic [p_nbits:0]     upper;
  logic [p_nbits-1:0]   diff;
  logic [2*p_nbits-1:0] r_step;

  // Upper window of {R, 0}: keeps the bit shifted out of R so large divisors compare right.
  assign upper  = r_q[2*p_nbits-1:p_nbits-1];
  assign sub_ok = upper >= {1'b0, d_q};
  // When upper >= D the true difference fits in N bits, so the low N bits suffice.
  assign diff   = upper[p_nbits-1:0] - d_q;

  always_comb begin
    r_step = {r_q[2*p_nbits-2:0], 1'b0};
    if (use_diff) begin
      r_step = {diff, r_q[p_nbits-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      d_q <= '0;
    end else if (load) begin
      r_q <= {{p_nbits{1'b0}}, dividend};
      d_q <= divisor;
    end else if (step) begin
      r_q <= r_step;
    end
  end

  assign rem_quo = r_q;

endmodule

// File: rtl/int_div_iterative.sv
// Iterative unsigned divider with val/rdy streams: one restoring step per cycle,
// N CALC cycles then a DONE cycle holding {remainder, quotient}.
module int_div_iterative
  import int_div_pkg::*;
#(
  parameter int unsigned p_nbits = DefaultNbits
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [2*p_nbits-1:0] istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [2*p_nbits-1:0] ostream_msg
);

  localparam int unsigned CntW = $clog2(p_nbits);
  localparam logic [CntW-1:0] LastCnt = CntW'(p_nbits - 1);

  state_e          state;
  logic [CntW-1:0] cnt;
  logic            load;
  logic            step;
  logic            sub_ok;

  assign load = (state == StIdle) && istream_val && istream_rdy;
  assign step = (state == StCalc);

  // istream_rdy/ostream_val are registered alongside the state so that they drop
  // during reset and never depend combinationally on any input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      cnt         <= '0;
      istream_rdy <= 1'b0;
      ostream_val <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          istream_rdy <= 1'b1;
          if (istream_val && istream_rdy) begin
            state       <= StCalc;
            cnt         <= '0;
            istream_rdy <= 1'b0;
          end
        end
        StCalc: begin
          cnt <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            state       <= StDone;
            ostream_val <= 1'b1;
          end
        end
        StDone: begin
          if (ostream_rdy) begin
            state       <= StIdle;
            ostream_val <= 1'b0;
            istream_rdy <= 1'b1;
          end
        end
        default: begin
          state       <= StIdle;
          istream_rdy <= 1'b0;
          ostream_val <= 1'b0;
        end
      endcase
    end
  end

  int_div_iterative_dpath #(
    .p_nbits(p_nbits)
  ) u_dpath (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .use_diff(sub_ok),
    .dividend(istream_msg[2*p_nbits-1:p_nbits]),
    .divisor (istream_msg[p_nbits-1:0]),
    .sub_ok  (sub_ok),
    .rem_quo (ostream_msg)
  );

endmodule
